// File: rtl/mux_n_pipe.sv
// N-input WIDTH-bit selector feeding a registered valid/ready output with a two-entry skid buffer.
// Optional sticky out-of-range select flag is built when MUX_N_PIPE_SEL_CHECK_EN is defined.
module mux_n_pipe #(
  parameter int WIDTH  = 32,
  parameter int INPUTS = 4,
  parameter int SEL_W  = $clog2(INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  // Unmatched select values fall through to the all-zero default.
  function automatic logic [WIDTH-1:0] select_word(
    input logic [INPUTS*WIDTH-1:0] d,
    input logic [SEL_W-1:0]        s
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < INPUTS; k++) begin
      if (s == SEL_W'(k)) r = d[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  logic [WIDTH-1:0] sel_word_p0;
  logic             vld_p0;
  logic             consume;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  // Stage p0: combinational select and handshake qualification.
  assign sel_word_p0 = select_word(in_data, in_sel);
  assign in_ready    = ~skid_valid;
  assign vld_p0      = in_valid & in_ready & ~flush;
  assign consume     = out_valid & out_ready;

  // Stage p1: main output register and skid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || consume) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (vld_p0) begin
        out_data  <= sel_word_p0;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (vld_p0) begin
      skid_valid <= 1'b1;
    end
  end

  // The skid payload is qualified by skid_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && out_valid && !consume && vld_p0) skid_data <= sel_word_p0;
  end

`ifdef MUX_N_PIPE_SEL_CHECK_EN
  logic sel_oor;
  logic sel_err_q;

  assign sel_oor = {1'b0, in_sel} >= (SEL_W+1)'(INPUTS);

  always_ff @(posedge clk) begin
    if (rst) sel_err_q <= 1'b0;
    else if (vld_p0 && sel_oor) sel_err_q <= 1'b1;
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

endmodule
